// File: rtl/multi_state_seq.sv
// Multi-cycle MIPS step sequencer: IF/ID/EX/MEM/WB state register with memory-ready stalls,
// halt at instruction boundaries, illegal-op / watchdog trap and a retired-instruction count.
module multi_state_seq #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned WAIT_W      = 8,
    parameter int unsigned MEM_TIMEOUT = 200
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [5:0]       op_i,
    input  logic             next_ins_i,
    input  logic             mem_ready_i,
    input  logic             halt_req_i,
    output logic [2:0]       state_o,
    output logic             step_en_o,
    output logic             mem_req_o,
    output logic             halted_o,
    output logic             trapped_o,
    output logic             illegal_op_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] retired_o
);

    typedef enum logic [2:0] {
        StIf   = 3'd0,
        StId   = 3'd1,
        StEx   = 3'd2,
        StMem  = 3'd3,
        StWb   = 3'd4,
        StHalt = 3'd5,
        StTrap = 3'd6
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [WAIT_W-1:0] WaitLast = WAIT_W'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              illegal_q, illegal_d;
    logic              timeout_q, timeout_d;
    logic              halted_q, trapped_q;
    logic              op_legal, mem_step, retire;

    always_comb begin
        op_legal = op_i inside {OpRtype, OpLw, OpSw, OpBeq, OpAddi, OpJ};
        mem_step = (state_q == StIf) || (state_q == StMem && (op_i == OpLw || op_i == OpSw));
    end

    // Parked states present ID to the decoder so every decoder enable is inactive.
    always_comb begin
        mem_req_o = !reset_i && mem_step;
        if (reset_i) begin
            step_en_o = 1'b0;
        end else if (mem_step) begin
            step_en_o = mem_ready_i;
        end else if (state_q == StId) begin
            step_en_o = op_legal;
        end else begin
            step_en_o = (state_q == StEx) || (state_q == StMem) || (state_q == StWb);
        end
        state_o = (state_q == StHalt || state_q == StTrap) ? 3'b001 : state_q;
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        retired_d = retired_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        retire    = 1'b0;
        if (mem_step && !mem_ready_i) begin
            if (wait_q == WaitLast) begin
                state_d   = StTrap;
                timeout_d = 1'b1;
            end else begin
                wait_d = wait_q + WAIT_W'(1);
            end
        end else begin
            case (state_q)
                StIf:  state_d = StId;
                StId: begin
                    if (op_legal) begin
                        state_d = StEx;
                    end else begin
                        state_d   = StTrap;
                        illegal_d = 1'b1;
                    end
                end
                StEx:  if (next_ins_i) retire = 1'b1; else state_d = StMem;
                StMem: if (next_ins_i) retire = 1'b1; else state_d = StWb;
                StWb:  retire = 1'b1;
                StHalt: if (!halt_req_i) state_d = StIf;
                StTrap: state_d = StTrap;
                default: state_d = StIf;
            endcase
        end
        if (retire) begin
            retired_d = retired_q + CNT_W'(1);
            state_d   = halt_req_i ? StHalt : StIf;
        end
        if (state_d != state_q) begin
            wait_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StIf;
            wait_q    <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            halted_q  <= 1'b0;
            trapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            halted_q  <= (state_d == StHalt);
            trapped_q <= (state_d == StTrap);
        end
    end

    assign halted_o      = halted_q;
    assign trapped_o     = trapped_q;
    assign illegal_op_o  = illegal_q;
    assign mem_timeout_o = timeout_q;
    assign retired_o     = retired_q;

endmodule

// File: tb/tb_multi_state_seq.sv
// Bench for multi_state_seq: directed vector table, hand-written corner sequences and a
// randomized run against an instruction-step-list reference model.
module tb_multi_state_seq;

    localparam int TO = 4;
    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;

    logic       clk = 1'b0;
    logic       rst, mr, hr, ni;
    logic [5:0] op;
    logic [2:0] st, st_w;
    logic       se, mq, hlt, trp, ill, mto;
    logic       se_w, mq_w, hlt_w, trp_w, ill_w, mto_w;
    logic [7:0] ret;
    logic [1:0] ret_w;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multi_state_seq #(.CNT_W(8), .WAIT_W(8), .MEM_TIMEOUT(TO)) dut (
        .clk_i(clk), .reset_i(rst), .op_i(op), .next_ins_i(ni), .mem_ready_i(mr),
        .halt_req_i(hr), .state_o(st), .step_en_o(se), .mem_req_o(mq), .halted_o(hlt),
        .trapped_o(trp), .illegal_op_o(ill), .mem_timeout_o(mto), .retired_o(ret)
    );

    multi_state_seq #(.CNT_W(2), .WAIT_W(8), .MEM_TIMEOUT(TO)) dut_w (
        .clk_i(clk), .reset_i(rst), .op_i(op), .next_ins_i(ni), .mem_ready_i(mr),
        .halt_req_i(hr), .state_o(st_w), .step_en_o(se_w), .mem_req_o(mq_w), .halted_o(hlt_w),
        .trapped_o(trp_w), .illegal_op_o(ill_w), .mem_timeout_o(mto_w), .retired_o(ret_w)
    );

    typedef struct {
        logic       mr, hr, ni;
        logic [5:0] op;
        logic [2:0] st;
        logic       se, mq;
        logic [7:0] ret;
        logic       hlt, trp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(int m, int h, int n, logic [5:0] o, int s, int e, int q,
                               int r, int hl, int tp);
        vec_t x;
        x.mr = m[0]; x.hr = h[0]; x.ni = n[0]; x.op = o; x.st = s[2:0];
        x.se = e[0]; x.mq = q[0]; x.ret = r[7:0]; x.hlt = hl[0]; x.trp = tp[0];
        return x;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic m, input logic h, input logic n,
                         input logic [5:0] o);
        rst = r; mr = m; hr = h; ni = n; op = o;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        drive(1'b1, 1'b1, 1'b0, 1'b0, R);
        chk("rst_step_en", int'(se), 0);
        chk("rst_mem_req", int'(mq), 0);
        tick();
    endtask

    function automatic int ilen(logic [5:0] o);
        if (o == BEQ || o == J) return 3;
        if (o == LW) return 5;
        return 4;
    endfunction

    function automatic bit legal(logic [5:0] o);
        return o == R || o == LW || o == SW || o == BEQ || o == ADDI || o == J;
    endfunction

    // Reference model state: mode 0 running step k of an instruction, 1 halted, 2 trapped.
    int         m_mode, m_k, m_wait, m_ret, m_ill, m_mto;
    logic [5:0] m_op;

    initial begin
        logic [5:0] ops[6];
        int stall;
        logic r, m, h, n;
        bit memstep;
        int exp_se;
        ops = '{R, LW, SW, BEQ, ADDI, J};

        // R-type, lw with stalls, addi with halt, beq, j
        tbl.push_back(v(1, 0, 0, R, 0, 1, 1, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, R, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, R, 2, 1, 0, 0, 0, 0));
        tbl.push_back(v(1, 0, 1, R, 3, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, LW, 0, 0, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, LW, 0, 0, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, LW, 0, 0, 1, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, LW, 0, 1, 1, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, LW, 1, 1, 0, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, LW, 2, 1, 0, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, LW, 3, 0, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, LW, 3, 0, 1, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, LW, 3, 1, 1, 1, 0, 0));
        tbl.push_back(v(1, 0, 1, LW, 4, 1, 0, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, ADDI, 0, 1, 1, 2, 0, 0));
        tbl.push_back(v(1, 0, 0, ADDI, 1, 1, 0, 2, 0, 0));
        tbl.push_back(v(1, 1, 0, ADDI, 2, 1, 0, 2, 0, 0));
        tbl.push_back(v(1, 1, 1, ADDI, 3, 1, 0, 2, 0, 0));
        tbl.push_back(v(1, 1, 0, ADDI, 1, 0, 0, 3, 1, 0));
        tbl.push_back(v(1, 0, 0, ADDI, 1, 0, 0, 3, 1, 0));
        tbl.push_back(v(1, 0, 0, BEQ, 0, 1, 1, 3, 0, 0));
        tbl.push_back(v(1, 0, 0, BEQ, 1, 1, 0, 3, 0, 0));
        tbl.push_back(v(1, 0, 1, BEQ, 2, 1, 0, 3, 0, 0));
        tbl.push_back(v(1, 0, 0, J, 0, 1, 1, 4, 0, 0));

        do_reset();
        foreach (tbl[i]) begin
            drive(1'b0, tbl[i].mr, tbl[i].hr, tbl[i].ni, tbl[i].op);
            chk($sformatf("tbl%0d_state", i), int'(st), int'(tbl[i].st));
            chk($sformatf("tbl%0d_step_en", i), int'(se), int'(tbl[i].se));
            chk($sformatf("tbl%0d_mem_req", i), int'(mq), int'(tbl[i].mq));
            chk($sformatf("tbl%0d_retired", i), int'(ret), int'(tbl[i].ret));
            chk($sformatf("tbl%0d_halted", i), int'(hlt), int'(tbl[i].hlt));
            chk($sformatf("tbl%0d_trapped", i), int'(trp), int'(tbl[i].trp));
            tick();
        end

        // Illegal opcode traps from ID; only reset leaves TRAP
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 6'h3f);
        chk("ill_if_state", int'(st), 0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 6'h3f);
        chk("ill_id_state", int'(st), 1);
        chk("ill_id_step_en", int'(se), 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1, 6'h3f);
            chk("ill_trapped", int'(trp), 1);
            chk("ill_sticky", int'(ill), 1);
            chk("ill_trap_state", int'(st), 1);
            chk("ill_trap_step_en", int'(se), 0);
            chk("ill_trap_mem_req", int'(mq), 0);
            chk("ill_retired", int'(ret), 0);
            tick();
        end
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, R);
        chk("ill_rst_state", int'(st), 0);
        chk("ill_rst_sticky", int'(ill), 0);
        chk("ill_rst_trapped", int'(trp), 0);

        // Watchdog expiry in IF, then the same-cycle-ready variant
        do_reset();
        for (int i = 0; i < TO; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, LW);
            chk("wd_if_state", int'(st), 0);
            chk("wd_if_mem_req", int'(mq), 1);
            chk("wd_if_trapped", int'(trp), 0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, LW);
        chk("wd_trapped", int'(trp), 1);
        chk("wd_timeout", int'(mto), 1);
        chk("wd_illegal", int'(ill), 0);
        chk("wd_mem_req", int'(mq), 0);
        do_reset();
        for (int i = 0; i < TO; i++) begin
            drive(1'b0, (i == TO - 1), 1'b0, 1'b0, LW);
            tick();
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, LW);
        chk("wd_ready_state", int'(st), 1);
        chk("wd_ready_trapped", int'(trp), 0);
        chk("wd_ready_timeout", int'(mto), 0);

        // Reset in the middle of a lw, then counter wrap on the 2-bit instance
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, LW); tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, LW); tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, LW); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, LW);
        chk("abort_mem_state", int'(st), 3);
        tick();
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, LW);
        chk("abort_state", int'(st), 0);
        chk("abort_retired", int'(ret), 0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, J); tick();
            drive(1'b0, 1'b1, 1'b0, 1'b0, J); tick();
            drive(1'b0, 1'b1, 1'b0, 1'b1, J); tick();
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, J);
        chk("wrap_retired_w", int'(ret_w), 0);
        chk("wrap_retired", int'(ret), 4);

        // Randomized run against the step-list model
        do_reset();
        m_mode = 0; m_k = 0; m_wait = 0; m_ret = 0; m_ill = 0; m_mto = 0; m_op = R;
        stall = 0;
        h = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            r = ($urandom_range(0, 299) == 0) || (m_mode == 2 && $urandom_range(0, 5) == 0);
            if (m_mode == 0 && m_k == 0) begin
                if ($urandom_range(0, 9) == 0) m_op = 6'($urandom_range(0, 63));
                else m_op = ops[$urandom_range(0, 5)];
            end
            if (stall == 0 && $urandom_range(0, 39) == 0) stall = $urandom_range(3, 6);
            if (stall > 0) begin
                m = 1'b0;
                stall--;
            end else begin
                m = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 9) == 0) h = !h;
            n = (m_mode == 0 && m_k == ilen(m_op) - 1);
            drive(r, m, h, n, m_op);

            memstep = (m_mode == 0) && (m_k == 0 || (m_k == 3 && (m_op == LW || m_op == SW)));
            if (r) begin
                chk("rnd_rst_step_en", int'(se), 0);
                chk("rnd_rst_mem_req", int'(mq), 0);
            end else begin
                if (m_mode != 0) exp_se = 0;
                else if (memstep) exp_se = int'(m);
                else if (m_k == 1) exp_se = int'(legal(m_op));
                else exp_se = 1;
                chk("rnd_state", int'(st), (m_mode == 0) ? m_k : 1);
                chk("rnd_step_en", int'(se), exp_se);
                chk("rnd_mem_req", int'(mq), int'(memstep));
                chk("rnd_halted", int'(hlt), int'(m_mode == 1));
                chk("rnd_trapped", int'(trp), int'(m_mode == 2));
                chk("rnd_illegal", int'(ill), m_ill);
                chk("rnd_timeout", int'(mto), m_mto);
                chk("rnd_retired", int'(ret), m_ret % 256);
                chk("rnd_retired_w", int'(ret_w), m_ret % 4);
            end
            tick();

            if (r) begin
                m_mode = 0; m_k = 0; m_wait = 0; m_ret = 0; m_ill = 0; m_mto = 0;
            end else if (m_mode == 0) begin
                if (memstep && !m) begin
                    if (m_wait == TO - 1) begin
                        m_mode = 2; m_mto = 1;
                    end else begin
                        m_wait++;
                    end
                end else if (m_k == 1 && !legal(m_op)) begin
                    m_mode = 2; m_ill = 1;
                end else if (m_k == ilen(m_op) - 1) begin
                    m_ret++; m_k = 0; m_wait = 0;
                    m_mode = h ? 1 : 0;
                end else begin
                    m_k++; m_wait = 0;
                end
            end else if (m_mode == 1 && !h) begin
                m_mode = 0; m_k = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
